// File: rtl/fwd_arb_rr_if.sv
// Forwarder / packet-filter-core arbitration bus.
// The master side is the forwarder plus the cores. The slave side is the arbiter.
interface fwd_arb_rr_if #(
  parameter int N                 = 4,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH        = 32
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  // Forwarder side
  logic [SN_FWD_ADDR_WIDTH-1:0]   addr;
  logic                           rd_en;
  logic [SN_FWD_DATA_WIDTH-1:0]   rd_data;
  logic                           rd_data_vld;
  logic [PLEN_WIDTH-1:0]          byte_len;
  logic                           done;
  logic                           rdy;
  logic                           ack;

  // Core side
  logic [SN_FWD_ADDR_WIDTH-1:0]   fwd_addr;
  logic [N-1:0]                   fwd_rd_en;
  logic [N*SN_FWD_DATA_WIDTH-1:0] fwd_rd_data;
  logic [N-1:0]                   fwd_rd_data_vld;
  logic [N*PLEN_WIDTH-1:0]        fwd_byte_len;
  logic [N-1:0]                   fwd_done;
  logic [N-1:0]                   rdy_for_fwd;
  logic [N-1:0]                   rdy_for_fwd_ack;

  // Status
  logic [SEL_W-1:0]               sel_idx;
  logic                           busy;

  modport master (
    output addr, rd_en, done, ack, fwd_rd_data, fwd_rd_data_vld, fwd_byte_len, rdy_for_fwd,
    input  rd_data, rd_data_vld, byte_len, rdy, fwd_addr, fwd_rd_en, fwd_done,
           rdy_for_fwd_ack, sel_idx, busy
  );

  modport slave (
    input  addr, rd_en, done, ack, fwd_rd_data, fwd_rd_data_vld, fwd_byte_len, rdy_for_fwd,
    output rd_data, rd_data_vld, byte_len, rdy, fwd_addr, fwd_rd_en, fwd_done,
           rdy_for_fwd_ack, sel_idx, busy
  );
endinterface

// File: rtl/fwd_arb_rr.sv
// Round-robin (or fixed-priority) arbiter that hands one forwarder to N
// packet-filter cores. A core is granted on the rdy/ack handshake. The arbiter
// then owns the forwarder until done. The read return path is muxed from the
// granted core through MUX_LAT register stages.
module fwd_arb_rr #(
  parameter int N                 = 4,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH        = 32,
  parameter int MUX_LAT           = 1,
  parameter int RR_EN             = 1
) (
  input logic          clk,
  input logic          rst,
  fwd_arb_rr_if.slave  bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam int DW    = SN_FWD_DATA_WIDTH;
  localparam int LW    = PLEN_WIDTH;

  typedef enum logic {IDLE = 1'b0, FWD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_nxt, sel_q, base, win;
  logic [N-1:0]     req, req_rot;
  logic [N-1:0]     ack_vec, rd_en_vec, done_vec;
  logic             offer, hs;

  logic [DW-1:0]    mux_data;
  logic             mux_vld;
  logic [LW-1:0]    mux_len;

  assign req     = bus.rdy_for_fwd;
  assign offer   = (state_q == IDLE) && (|req);
  // A handshake is suppressed while rst is high, so no grant pulse escapes.
  assign hs      = offer && bus.ack && !rst;
  // In fixed-priority mode the search always starts at core 0.
  assign base    = (RR_EN != 0) ? ptr_q : '0;
  // Rotate the request vector so that bit 0 is the first core to consider.
  assign req_rot = N'({req, req} >> base);

  // Winner search. Scanning downward leaves the lowest rotated index in win.
  // The pointer update is the winner plus one, wrapped to the range 0..N-1.
  always_comb begin
    int sum;
    int nxt;
    // NOTE: defaults come first so that every path assigns every variable; this
    // prevents an inferred latch.
    sum     = 0;
    nxt     = 0;
    win     = '0;
    ptr_nxt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum = int'(base) + k;
        if (sum >= N) sum = sum - N;
      end
    end
    win = SEL_W'(sum);
    nxt = sum + 1;
    if (nxt >= N) nxt = 0;
    ptr_nxt = SEL_W'(nxt);
  end

  // Next state: a handshake opens a packet, and done closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = FWD;
      FWD:     if (bus.done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register the FSM, the round-robin pointer and the grantee index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // whatever order the statements are written in.
      state_q <= state_d;
      if (hs) begin
        ptr_q <= ptr_nxt;
        sel_q <= win;
      end
    end
  end

  // One-hot grant pulse, and strobes gated to the current grantee only.
  always_comb begin
    ack_vec   = '0;
    rd_en_vec = '0;
    done_vec  = '0;
    for (int i = 0; i < N; i++) begin
      if (hs && (win == SEL_W'(i))) ack_vec[i] = 1'b1;
      if ((state_q == FWD) && (sel_q == SEL_W'(i))) begin
        rd_en_vec[i] = bus.rd_en;
        done_vec[i]  = bus.done;
      end
    end
  end

  // Return-path mux. Valid is blanked while no packet is owned.
  always_comb begin
    mux_data = '0;
    mux_vld  = 1'b0;
    mux_len  = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_q == SEL_W'(i)) begin
        mux_data = bus.fwd_rd_data[i*DW +: DW];
        mux_vld  = bus.fwd_rd_data_vld[i];
        mux_len  = bus.fwd_byte_len[i*LW +: LW];
      end
    end
    if (state_q == IDLE) mux_vld = 1'b0;
  end

  generate
    if (MUX_LAT == 0) begin : g_comb
      assign bus.rd_data     = mux_data;
      assign bus.rd_data_vld = mux_vld;
      assign bus.byte_len    = mux_len;
    end else begin : g_pipe
      logic [DW-1:0] data_q [MUX_LAT];
      logic          vld_q  [MUX_LAT];
      logic [LW-1:0] len_q  [MUX_LAT];

      // Return-path delay line. It keeps draining after done.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          // NOTE: these stage arrays are registers, not a RAM. They take the
          // async reset like any other flop, so rst clears in-flight valids.
          for (int s = 0; s < MUX_LAT; s++) begin
            data_q[s] <= '0;
            vld_q[s]  <= 1'b0;
            len_q[s]  <= '0;
          end
        end else begin
          data_q[0] <= mux_data;
          vld_q[0]  <= mux_vld;
          len_q[0]  <= mux_len;
          for (int s = 1; s < MUX_LAT; s++) begin
            data_q[s] <= data_q[s-1];
            vld_q[s]  <= vld_q[s-1];
            len_q[s]  <= len_q[s-1];
          end
        end
      end

      assign bus.rd_data     = data_q[MUX_LAT-1];
      assign bus.rd_data_vld = vld_q[MUX_LAT-1];
      assign bus.byte_len    = len_q[MUX_LAT-1];
    end
  endgenerate

  assign bus.rdy             = offer;
  assign bus.rdy_for_fwd_ack = ack_vec;
  assign bus.fwd_rd_en       = rd_en_vec;
  assign bus.fwd_done        = done_vec;
  assign bus.fwd_addr        = bus.addr;
  assign bus.sel_idx         = sel_q;
  assign bus.busy            = (state_q == FWD);
endmodule

// File: tb/tb_fwd_arb_rr.sv
// Directed bench for fwd_arb_rr. It uses four configurations:
//   b0: N=4, round-robin, MUX_LAT=2
//   b1: N=4, fixed priority, MUX_LAT=0
//   b2: N=1, MUX_LAT=1
//   b3: N=5, round-robin, MUX_LAT=1
module tb_fwd_arb_rr;
  logic clk;
  logic rst;

  typedef struct {
    logic [63:0] d;
    logic [31:0] l;
  } beat_t;

  beat_t data_q[$];
  int    grant_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    ptr3     = 0;

  fwd_arb_rr_if #(.N(4)) b0 ();
  fwd_arb_rr_if #(.N(4)) b1 ();
  fwd_arb_rr_if #(.N(1)) b2 ();
  fwd_arb_rr_if #(.N(5)) b3 ();

  fwd_arb_rr #(.N(4), .RR_EN(1), .MUX_LAT(2)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  fwd_arb_rr #(.N(4), .RR_EN(0), .MUX_LAT(0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  fwd_arb_rr #(.N(1), .RR_EN(1), .MUX_LAT(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  fwd_arb_rr #(.N(5), .RR_EN(1), .MUX_LAT(1)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin pick for the five-core configuration.
  function automatic int rr_pick5(input logic [4:0] req, input int ptr);
    for (int k = 0; k < 5; k++) begin
      int idx;
      idx = (ptr + k) % 5;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  // b0: handshake, then check the grant pulse and the registered index.
  task automatic grant0(input logic [3:0] req, input int exp_w);
    int w;
    grant_q.push_back(exp_w);
    b0.rdy_for_fwd = req;
    b0.ack = 1'b1;
    #1;
    w = grant_q.pop_front();
    check("b0_rdy", 64'(b0.rdy), 64'd1);
    check("b0_ack_pulse", 64'(b0.rdy_for_fwd_ack), 64'd1 << w);
    step();
    b0.ack = 1'b0;
    #1;
    check("b0_busy_fwd", 64'(b0.busy), 64'd1);
    check("b0_sel_idx", 64'(b0.sel_idx), 64'(w));
    check("b0_ack_cleared", 64'(b0.rdy_for_fwd_ack), 64'd0);
  endtask

  // b0: gated strobes during FWD, then done. An ack in the done cycle must be ignored.
  task automatic finish0(input int w);
    b0.rd_en = 1'b1;
    #1;
    check("b0_fwd_rd_en", 64'(b0.fwd_rd_en), 64'd1 << w);
    b0.rd_en = 1'b0;
    b0.done  = 1'b1;
    b0.ack   = 1'b1;
    #1;
    check("b0_fwd_done", 64'(b0.fwd_done), 64'd1 << w);
    check("b0_no_ack_in_done", 64'(b0.rdy_for_fwd_ack), 64'd0);
    step();
    b0.done = 1'b0;
    b0.ack  = 1'b0;
    #1;
    check("b0_busy_idle", 64'(b0.busy), 64'd0);
  endtask

  // b3: one complete back-to-back packet, with the expected winner taken from the model.
  task automatic pkt3(input logic [4:0] req);
    int w;
    grant_q.push_back(rr_pick5(req, ptr3));
    b3.rdy_for_fwd = req;
    b3.ack = 1'b1;
    #1;
    w = grant_q.pop_front();
    check("b3_ack_pulse", 64'(b3.rdy_for_fwd_ack), 64'd1 << w);
    check("b3_ack_onehot", 64'($onehot(b3.rdy_for_fwd_ack)), 64'd1);
    step();
    b3.ack = 1'b0;
    #1;
    check("b3_sel_idx", 64'(b3.sel_idx), 64'(w));
    b3.done = 1'b1;
    b3.ack  = 1'b1;
    #1;
    check("b3_no_ack_in_done", 64'(b3.rdy_for_fwd_ack), 64'd0);
    step();
    b3.done = 1'b0;
    b3.ack  = 1'b0;
    ptr3 = (w + 1) % 5;
  endtask

  initial begin
    beat_t b;
    int exp_seq [5] = '{0, 1, 2, 3, 0};

    rst = 1'b0;
    b0.addr = '0; b0.rd_en = 0; b0.done = 0; b0.ack = 0; b0.rdy_for_fwd = '0;
    b0.fwd_rd_data = '0; b0.fwd_rd_data_vld = '0; b0.fwd_byte_len = '0;
    b1.addr = '0; b1.rd_en = 0; b1.done = 0; b1.ack = 0; b1.rdy_for_fwd = '0;
    b1.fwd_rd_data = '0; b1.fwd_rd_data_vld = '0; b1.fwd_byte_len = '0;
    b2.addr = '0; b2.rd_en = 0; b2.done = 0; b2.ack = 0; b2.rdy_for_fwd = '0;
    b2.fwd_rd_data = '0; b2.fwd_rd_data_vld = '0; b2.fwd_byte_len = '0;
    b3.addr = '0; b3.rd_en = 0; b3.done = 0; b3.ack = 0; b3.rdy_for_fwd = '0;
    b3.fwd_rd_data = '0; b3.fwd_rd_data_vld = '0; b3.fwd_byte_len = '0;
    #2 rst = 1'b1;
    step();
    step();

    // Values held in reset
    check("rst_busy", 64'(b0.busy), 64'd0);
    check("rst_sel_idx", 64'(b0.sel_idx), 64'd0);
    check("rst_rd_data_vld", 64'(b0.rd_data_vld), 64'd0);
    check("rst_rd_data", b0.rd_data, 64'd0);
    check("rst_rdy", 64'(b0.rdy), 64'd0);
    rst = 1'b0;
    #1;

    // Stimulus in IDLE: done, rd_en and ack with nothing on offer
    b0.addr = 8'hA5; b0.rd_en = 1'b1; b0.done = 1'b1; b0.ack = 1'b1;
    #1;
    check("idle_fwd_addr", 64'(b0.fwd_addr), 64'hA5);
    check("idle_fwd_done", 64'(b0.fwd_done), 64'd0);
    check("idle_fwd_rd_en", 64'(b0.fwd_rd_en), 64'd0);
    check("idle_no_grant", 64'(b0.rdy_for_fwd_ack), 64'd0);
    step();
    check("idle_stays_idle", 64'(b0.busy), 64'd0);
    b0.rd_en = 1'b0; b0.done = 1'b0; b0.ack = 1'b0;

    // All four cores requesting: grants 0,1,2,3 then back to 0
    for (int p = 0; p < 5; p++) begin
      grant0(4'b1111, exp_seq[p]);
      finish0(exp_seq[p]);
    end

    // Core 2 granted. With MUX_LAT=2, data appears two edges later.
    grant0(4'b0100, 2);
    b0.fwd_rd_data  = {64'h3333_3333_3333_3333, 64'hC2C2_0000_1234_5678,
                       64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
    b0.fwd_byte_len = {32'd300, 32'd222, 32'd100, 32'd0};
    b0.fwd_rd_data_vld = 4'b0110;
    b.d = 64'hC2C2_0000_1234_5678;
    b.l = 32'd222;
    data_q.push_back(b);
    step();
    b0.fwd_rd_data_vld = '0;
    check("lat2_not_yet", 64'(b0.rd_data_vld), 64'd0);
    step();
    check("lat2_vld", 64'(b0.rd_data_vld), 64'd1);
    if (data_q.size() != 0) begin
      b = data_q.pop_front();
      check("lat2_rd_data", b0.rd_data, b.d);
      check("lat2_byte_len", 64'(b0.byte_len), 64'(b.l));
    end
    step();
    check("lat2_vld_drop", 64'(b0.rd_data_vld), 64'd0);

    // rst asserted mid-FWD with a valid beat at the output
    b0.fwd_rd_data_vld = 4'b0100;
    step();
    b0.fwd_rd_data_vld = '0;
    step();
    check("inflight_vld", 64'(b0.rd_data_vld), 64'd1);
    b0.rdy_for_fwd = 4'b1111;
    b0.ack = 1'b1;
    b0.rd_en = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(b0.busy), 64'd0);
    check("midrst_vld", 64'(b0.rd_data_vld), 64'd0);
    check("midrst_sel", 64'(b0.sel_idx), 64'd0);
    check("midrst_ack", 64'(b0.rdy_for_fwd_ack), 64'd0);
    check("midrst_rd_en", 64'(b0.fwd_rd_en), 64'd0);
    step();
    check("midrst_drained", 64'(b0.rd_data_vld), 64'd0);
    rst = 1'b0;
    b0.ack = 1'b0;
    b0.rd_en = 1'b0;
    #1;
    grant0(4'b1111, 0);
    finish0(0);

    // Fixed priority with requests 4'b1010: core 1 wins each time
    b1.rdy_for_fwd = 4'b1010;
    #1;
    check("fp_rdy", 64'(b1.rdy), 64'd1);
    check("fp_no_ack_before", 64'(b1.rdy_for_fwd_ack), 64'd0);
    b1.ack = 1'b1;
    #1;
    check("fp_ack_pulse", 64'(b1.rdy_for_fwd_ack), 64'b0010);
    step();
    b1.ack = 1'b0;
    #1;
    check("fp_ack_after", 64'(b1.rdy_for_fwd_ack), 64'd0);
    check("fp_sel", 64'(b1.sel_idx), 64'd1);
    b1.fwd_rd_data = {64'hAAAA, 64'hBBBB, 64'hB1B1_B1B1_0000_0001, 64'hDDDD};
    b1.fwd_byte_len = {32'd9, 32'd8, 32'd77, 32'd6};
    b1.fwd_rd_data_vld = 4'b1010;
    b.d = 64'hB1B1_B1B1_0000_0001;
    b.l = 32'd77;
    data_q.push_back(b);
    #1;
    check("lat0_vld", 64'(b1.rd_data_vld), 64'd1);
    if (data_q.size() != 0) begin
      b = data_q.pop_front();
      check("lat0_rd_data", b1.rd_data, b.d);
      check("lat0_byte_len", 64'(b1.byte_len), 64'(b.l));
    end
    b1.fwd_rd_data_vld = '0;
    b1.done = 1'b1;
    step();
    b1.done = 1'b0;
    b1.ack = 1'b1;
    #1;
    check("fp_second_grant", 64'(b1.rdy_for_fwd_ack), 64'b0010);
    step();
    b1.ack = 1'b0;
    b1.done = 1'b1;
    step();
    b1.done = 1'b0;
    #1;
    check("fp_idle", 64'(b1.busy), 64'd0);

    // Single core: back-to-back packets always wrap to index 0
    b2.rdy_for_fwd = 1'b1;
    for (int p = 0; p < 3; p++) begin
      b2.ack = 1'b1;
      #1;
      check("n1_ack", 64'(b2.rdy_for_fwd_ack), 64'd1);
      step();
      b2.ack = 1'b0;
      #1;
      check("n1_sel", 64'(b2.sel_idx), 64'd0);
      check("n1_busy", 64'(b2.busy), 64'd1);
      if (p == 0) begin
        b2.fwd_rd_data = 64'h0000_D00D_0000_0001;
        b2.fwd_byte_len = 32'd5;
        b2.fwd_rd_data_vld = 1'b1;
        b.d = 64'h0000_D00D_0000_0001;
        b.l = 32'd5;
        data_q.push_back(b);
        step();
        b2.fwd_rd_data_vld = 1'b0;
        check("n1_lat1_vld", 64'(b2.rd_data_vld), 64'd1);
        if (data_q.size() != 0) begin
          b = data_q.pop_front();
          check("n1_lat1_data", b2.rd_data, b.d);
        end
      end
      b2.done = 1'b1;
      step();
      b2.done = 1'b0;
    end

    // Five cores: a full wrap, then sparse requests
    for (int p = 0; p < 6; p++) pkt3(5'b11111);
    pkt3(5'b10001);
    pkt3(5'b10001);
    check("n5_final_busy", 64'(b3.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fwd_arb_rr.md
FWD_ARB_RR -- requirements
Module: fwd_arb_rr

Interface
REQ-001 SHALL have parameter N, default 4: number of packetfilter cores arbitrated (1..64).
REQ-002 SHALL have parameter SN_FWD_ADDR_WIDTH, default 8: forwarder read address width.
REQ-003 SHALL have parameter SN_FWD_DATA_WIDTH, default 64: read data width per core.
REQ-004 SHALL have parameter PLEN_WIDTH, default 32: packet byte length width.
REQ-005 SHALL have parameter MUX_LAT, default 1: register stages on the core-to-forwarder return path (0..3).
REQ-006 SHALL have parameter RR_EN, default 1: 1 = round-robin grant; 0 = fixed priority, lowest index wins.
REQ-007 SHALL have one clock; reset is asynchronous and active-high: clk input 1 (all state on rising edge); rst input 1 (async, active-high).
REQ-008 SHALL have ports:
- addr in SN_FWD_ADDR_WIDTH: forwarder read address.
- rd_en in 1: forwarder read strobe.
- rd_data out SN_FWD_DATA_WIDTH: selected core data.
- rd_data_vld out 1: selected core data valid.
- byte_len out PLEN_WIDTH: selected core packet length.
- done in 1: forwarder finished packet.
- rdy out 1: a packet is on offer.
- ack in 1: forwarder accepts the offer.
- fwd_addr out SN_FWD_ADDR_WIDTH: address broadcast to all cores.
- fwd_rd_en out N: gated read strobes.
- fwd_rd_data in N*SN_FWD_DATA_WIDTH: core data, core i at slice i.
- fwd_rd_data_vld in N: per-core data valid.
- fwd_byte_len in N*PLEN_WIDTH: per-core length, core i at slice i.
- fwd_done out N: gated done.
- rdy_for_fwd in N: core i holds a packet for forwarding.
- rdy_for_fwd_ack out N: one-hot grant pulse.
- sel_idx out clog2(N) (min 1): index of current grantee.
- busy out 1: forwarding in progress.

Function
REQ-009 SHALL implement FSM states IDLE and FWD; reset state IDLE.
REQ-010 SHALL drive rdy = (state==IDLE) && |rdy_for_fwd, combinationally.
REQ-011 SHALL, when rdy && ack, select winner W, pulse rdy_for_fwd_ack[W] in that same cycle (combinational, exactly one bit), and on the next edge load sel_idx<=W and state<=FWD.
REQ-012 SHALL ignore ack while rdy=0; rdy_for_fwd_ack SHALL be all-zero outside a handshake cycle.
REQ-013 SHALL choose W, when RR_EN=1, as the first asserted rdy_for_fwd index searching upward from pointer ptr, wrapping N-1 to 0; when RR_EN=0, as the lowest asserted index.
REQ-014 SHALL reset ptr to 0 and, on each handshake, load ptr<=(W+1) mod N.
REQ-015 SHALL drive busy=1 exactly while state==FWD.
REQ-016 SHALL, in FWD, drive fwd_rd_en[i]=rd_en and fwd_done[i]=done for i==sel_idx only; all other bits 0.
REQ-017 SHALL drive fwd_rd_en and fwd_done all-zero in IDLE, regardless of rd_en/done.
REQ-018 SHALL, on done in FWD, return to IDLE on the next edge; a new handshake SHALL NOT occur in the done cycle.
REQ-019 SHALL drive fwd_addr=addr combinationally in all states.
REQ-020 SHALL select {fwd_rd_data, fwd_rd_data_vld, fwd_byte_len} slice sel_idx and present it on {rd_data, rd_data_vld, byte_len} after exactly MUX_LAT clock edges; MUX_LAT=0 is purely combinational.
REQ-021 SHALL force the mux-input rd_data_vld term to 0 while state==IDLE; pipeline stages continue to drain after done.
REQ-022 SHALL keep sel_idx stable from handshake until the next handshake.

Reset
REQ-023 SHALL, on rst assertion at any time including mid-packet, immediately set state=IDLE, ptr=0, sel_idx=0, clear all pipeline rd_data_vld stages to 0 and rd_data/byte_len stages to 0.
REQ-024 SHALL drive rdy_for_fwd_ack, fwd_rd_en, fwd_done and busy to 0 while rst is high.

Verification
REQ-025 SHALL cover: N=4, RR_EN=1, rdy_for_fwd=4'b1111 held, 4 handshake/done cycles -> grants to cores 0,1,2,3, then 0 again.
REQ-026 SHALL cover: RR_EN=0, rdy_for_fwd=4'b1010 -> first grant core 1, rdy_for_fwd_ack=4'b0010 in the ack cycle only.
REQ-027 SHALL cover: MUX_LAT=2, core 2 granted, fwd_rd_data_vld[2] pulse at cycle t -> rd_data_vld=1 at t+2 with core 2 data and byte_len.
REQ-028 SHALL cover: done in IDLE, rd_en in IDLE, and ack with rdy_for_fwd=0 -> fwd_done=0, fwd_rd_en=0, no grant, state unchanged.
REQ-029 SHALL cover: rst asserted mid-FWD with rd_data_vld in flight -> busy=0, rd_data_vld=0 immediately, next grant from ptr 0.
REQ-030 SHALL cover: N=1 and N=5, each with back-to-back packets -> correct wrap to index 0, one-hot ack throughout.
